// File: rtl/ped_pkg.sv
// ped_pkg: shared types for the pedestrian crossing controller.
//   ped_state_t : crossing FSM states
//   CD_W        : width of the seconds countdown display
package ped_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RED = 2'd1,
    WALK     = 2'd2,
    CLEAR    = 2'd3
  } ped_state_t;

  localparam int CD_W = 4;

endpackage

// File: rtl/ped_crossing_btn_debounce.sv
// btn_debounce: 2-FF synchronizer followed by a stable-count filter.
// The debounced level changes only after the synchronized input has
// differed from it for DEBOUNCE_CYC consecutive cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn        : raw asynchronous pushbutton
//   level      : debounced button level
//   rise       : one-cycle pulse on a rising edge of the debounced level
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync_p0, sync_p1;
  logic          level_p0;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      level    <= 1'b0;
      level_p0 <= 1'b0;
      rise     <= 1'b0;
      cnt      <= '0;
    end else begin
      // synchronizer stage
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      // filter stage: any return to the current level restarts the count
      if (sync_p1 != level) begin
        if (cnt == CW'(DEBOUNCE_CYC - 1)) begin
          level <= sync_p1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
      // edge stage
      level_p0 <= level;
      rise     <= level & ~level_p0;
    end
  end

endmodule

// File: rtl/ped_crossing_ctrl.sv
// ped_crossing_ctrl: pedestrian crossing controller downstream of the
// vehicle sequencer. Grants WALK only at the start of a fresh vehicle red
// phase, follows it with a flashing clearance phase, and aborts to IDLE
// with a sticky conflict flag if vehicle red is lost while crossing.
// Optional feature macro: PED_AUDIO_EN (audible cue on beep); without it
// beep is tied low.
//   clk, rst_n                   : clock, asynchronous active-low reset
//   veh_red/veh_blue/veh_green   : vehicle lamp states (synchronous)
//   btn                          : raw pedestrian pushbutton
//   walk, dont_walk              : pedestrian lamps (registered)
//   req_pending                  : latched request not yet served
//   countdown                    : seconds until solid DON'T-WALK
//   conflict                     : sticky safety fault
//   beep                         : audible cue
module ped_crossing_ctrl
  import ped_pkg::*;
#(
  parameter int CLK_HZ       = 10_000_000,
  parameter int WALK_S       = 7,
  parameter int CLEAR_S      = 3,
  parameter int DEBOUNCE_CYC = 100_000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            veh_red,
  input  logic            veh_blue,
  input  logic            veh_green,
  input  logic            btn,
  output logic            walk,
  output logic            dont_walk,
  output logic            req_pending,
  output logic [CD_W-1:0] countdown,
  output logic            conflict,
  output logic            beep
);

  localparam int PW   = $clog2(CLK_HZ + 1);
  localparam int HALF = (CLK_HZ / 2 > 0) ? CLK_HZ / 2 : 1;
  localparam logic [PW-1:0] PS_LAST   = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] HALF_LAST = PW'(HALF - 1);

  ped_state_t      state, state_nx;
  logic [PW-1:0]   presc, presc_nx;
  logic [CD_W-1:0] cd_nx;
  logic            walk_nx, dw_nx, req_nx, conflict_nx;
  logic            qred, qred_p0, red_edge, tick;
  logic            btn_rise;
  // The debounced level itself is not needed; only its rise raises requests.
  logic            btn_level_unused;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_btn (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn),
    .level(btn_level_unused),
    .rise (btn_rise)
  );

  // Red counts only when it is the sole lamp lit.
  assign qred     = veh_red & ~veh_blue & ~veh_green;
  assign red_edge = qred & ~qred_p0;
  assign tick     = (presc == PS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      presc       <= '0;
      countdown   <= '0;
      walk        <= 1'b0;
      dont_walk   <= 1'b1;
      req_pending <= 1'b0;
      conflict    <= 1'b0;
      qred_p0     <= 1'b0;
    end else begin
      state       <= state_nx;
      presc       <= presc_nx;
      countdown   <= cd_nx;
      walk        <= walk_nx;
      dont_walk   <= dw_nx;
      req_pending <= req_nx;
      conflict    <= conflict_nx;
      qred_p0     <= qred;
    end
  end

  always_comb begin
    state_nx    = state;
    presc_nx    = presc;
    cd_nx       = countdown;
    walk_nx     = walk;
    dw_nx       = dont_walk;
    conflict_nx = conflict;
    req_nx      = req_pending | btn_rise;
    unique case (state)
      IDLE: begin
        walk_nx = 1'b0;
        dw_nx   = 1'b1;
        cd_nx   = '0;
        // Uses the registered flag, so a request latched on the same edge
        // as a red edge is left for the next red edge.
        if (req_pending) state_nx = WAIT_RED;
      end
      WAIT_RED: begin
        walk_nx = 1'b0;
        dw_nx   = 1'b1;
        cd_nx   = '0;
        if (red_edge) begin
          state_nx = WALK;
          walk_nx  = 1'b1;
          dw_nx    = 1'b0;
          cd_nx    = CD_W'(WALK_S + CLEAR_S);
          presc_nx = '0;
          req_nx   = btn_rise;
        end
      end
      WALK, CLEAR: begin
        if (!qred) begin
          state_nx    = IDLE;
          walk_nx     = 1'b0;
          dw_nx       = 1'b1;
          cd_nx       = '0;
          conflict_nx = 1'b1;
        end else begin
          presc_nx = tick ? '0 : presc + PW'(1);
          if (tick) cd_nx = countdown - CD_W'(1);
          if (state == WALK) begin
            if (tick && countdown == CD_W'(CLEAR_S + 1)) begin
              state_nx = CLEAR;
              walk_nx  = 1'b0;
              dw_nx    = 1'b1;
            end
          end else begin
            if (tick && countdown == CD_W'(1)) begin
              state_nx = IDLE;
              dw_nx    = 1'b1;
            end else if (tick || presc == HALF_LAST) begin
              dw_nx = ~dont_walk;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef PED_AUDIO_EN
  localparam int TONE_DIV = (CLK_HZ / 2000 > 0) ? CLK_HZ / 2000 : 1;
  localparam int TW       = $clog2(TONE_DIV + 1);

  logic [TW-1:0] tone_cnt;

  // Registered from next-state values so the cue lines up with the lamps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tone_cnt <= '0;
      beep     <= 1'b0;
    end else if (state_nx == WALK) begin
      if (state != WALK) begin
        tone_cnt <= '0;
        beep     <= 1'b0;
      end else if (tone_cnt == TW'(TONE_DIV - 1)) begin
        tone_cnt <= '0;
        beep     <= ~beep;
      end else begin
        tone_cnt <= tone_cnt + TW'(1);
      end
    end else begin
      tone_cnt <= '0;
      beep     <= (state_nx == CLEAR) ? dw_nx : 1'b0;
    end
  end
`else
  assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
module tb_ped_crossing_ctrl;
  import ped_pkg::*;

  logic            clk;
  logic            rst_n;
  logic            veh_red, veh_blue, veh_green, btn;
  logic            walk, dont_walk, req_pending, conflict, beep;
  logic [CD_W-1:0] countdown;
  logic [8:0]      obs;

  typedef struct {
    string      tag;
    logic [8:0] exp;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  ped_crossing_ctrl #(
    .CLK_HZ      (10),
    .WALK_S      (3),
    .CLEAR_S     (2),
    .DEBOUNCE_CYC(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .veh_red    (veh_red),
    .veh_blue   (veh_blue),
    .veh_green  (veh_green),
    .btn        (btn),
    .walk       (walk),
    .dont_walk  (dont_walk),
    .req_pending(req_pending),
    .countdown  (countdown),
    .conflict   (conflict),
    .beep       (beep)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {walk, dont_walk, req_pending, countdown[3:0], conflict, beep}
  assign obs = {walk, dont_walk, req_pending, countdown, conflict, beep};

  function automatic logic [8:0] mk(input logic w, input logic dw, input logic rq,
                                    input logic [3:0] cd, input logic cf);
    return {w, dw, rq, cd, cf, 1'b0};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic compare(input exp_t x);
    total++;
    assert (obs === x.exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", x.tag, obs, x.exp);
    end
  endtask

  // Deferred expectation: queued now, compared later with check_out.
  task automatic expect_out(input string tag, input logic [8:0] e);
    exp_t x;
    x.tag = tag;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic check_out();
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty: observed=%b expected=<entry>", obs);
    end else begin
      compare(sb.pop_front());
    end
  endtask

  // Immediate expectation: queued and compared at once.
  task automatic chk(input string tag, input logic [8:0] e);
    expect_out(tag, e);
    compare(sb.pop_back());
  endtask

  // The two lamps may never be lit together.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      total++;
      assert (!(walk === 1'b1 && dont_walk === 1'b1))
      else begin
        bad++;
        $error("FAIL lamp_excl: observed walk=%b dont_walk=%b expected not both 1",
               walk, dont_walk);
      end
    end
  end

  initial begin
    rst_n = 1'b0; btn = 1'b0;
    veh_red = 1'b0; veh_blue = 1'b0; veh_green = 1'b0;
    #23;
    chk("reset", mk(0, 1, 0, 4'd0, 0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(5);
    chk("idle", mk(0, 1, 0, 4'd0, 0));

    // short bounce: three samples high, then low
    btn = 1'b1;
    cyc(3);
    btn = 1'b0;
    cyc(10);
    chk("bounce", mk(0, 1, 0, 4'd0, 0));

    // held press: request appears 7 edges after the first sample
    btn = 1'b1;
    expect_out("deb_latency", mk(0, 1, 1, 4'd0, 0));
    cyc(6);
    chk("deb_early6", mk(0, 1, 0, 4'd0, 0));
    cyc(1);
    chk("deb_early7", mk(0, 1, 0, 4'd0, 0));
    cyc(1);
    check_out();
    btn = 1'b0;

    // red with blue is not a red phase
    veh_red = 1'b1; veh_blue = 1'b1;
    cyc(4);
    chk("blue_not_red", mk(0, 1, 1, 4'd0, 0));
    veh_blue = 1'b0;
    chk("pre_walk", mk(0, 1, 1, 4'd0, 0));

    // normal crossing
    for (int i = 1; i <= 30; i++) begin
      cyc(1);
      chk($sformatf("walk_%0d", i), mk(1, 0, 0, 4'(5 - (i - 1) / 10), 0));
    end
    for (int j = 0; j < 20; j++) begin
      cyc(1);
      chk($sformatf("clear_%0d", j),
          mk(0, ((j / 5) % 2) == 0, 0, 4'(2 - j / 10), 0));
    end
    cyc(1);
    chk("back_idle", mk(0, 1, 0, 4'd0, 0));

    // press while red already active: must wait for a fresh red
    btn = 1'b1;
    cyc(8);
    btn = 1'b0;
    chk("fresh_req", mk(0, 1, 1, 4'd0, 0));
    cyc(10);
    chk("fresh_hold", mk(0, 1, 1, 4'd0, 0));
    veh_red = 1'b0;
    cyc(3);
    chk("red_low", mk(0, 1, 1, 4'd0, 0));
    veh_red = 1'b1;
    cyc(1);
    chk("fresh_walk", mk(1, 0, 0, 4'd5, 0));

    // re-request during clearance
    cyc(30);
    chk("clear_entry", mk(0, 1, 0, 4'd2, 0));
    btn = 1'b1;
    cyc(10);
    btn = 1'b0;
    chk("clear_req", mk(0, 1, 1, 4'd1, 0));
    cyc(10);
    chk("rereq_idle", mk(0, 1, 1, 4'd0, 0));
    veh_red = 1'b0;
    cyc(2);
    veh_red = 1'b1;
    cyc(1);
    chk("rereq_walk", mk(1, 0, 0, 4'd5, 0));

    // safety abort: green while red still lit
    cyc(2);
    veh_green = 1'b1;
    chk("pre_abort", mk(1, 0, 0, 4'd5, 0));
    cyc(1);
    chk("abort", mk(0, 1, 0, 4'd0, 1));
    veh_green = 1'b0;
    cyc(5);
    chk("conflict_sticky", mk(0, 1, 0, 4'd0, 1));

    // reset asserted mid-WALK acts immediately
    btn = 1'b1;
    cyc(8);
    btn = 1'b0;
    chk("req_after_abort", mk(0, 1, 1, 4'd0, 1));
    cyc(2);
    veh_red = 1'b0;
    cyc(2);
    veh_red = 1'b1;
    cyc(1);
    chk("walk_again", mk(1, 0, 0, 4'd5, 1));
    cyc(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", mk(0, 1, 0, 4'd0, 0));
    cyc(2);
    chk("rst_hold", mk(0, 1, 0, 4'd0, 0));
    rst_n = 1'b1;
    cyc(3);
    chk("post_rst_idle", mk(0, 1, 0, 4'd0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
